// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - request/result bundle between control unit and HI/LO mul/div unit
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative signed/unsigned multiply/divide producing the HI/LO pair
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              clear,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic               is_div, zero_div, sign_a, sign_b;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH:0]     sum, shifted, trial;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               signed_mode, accept, last_iter, req_zero_div;

  assign signed_mode  = ~bus.op[0];
  assign mag_a        = (signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b        = (signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign accept       = (state == IDLE) && bus.start;
  assign req_zero_div = bus.op[1] && (bus.b == '0);
  assign last_iter    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = req_zero_div ? FIX : RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted = acc[2*WIDTH-1:WIDTH-1];
    trial   = shifted - {1'b0, addend};
    if (is_div) begin
      if (trial[WIDTH]) acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else              acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0]) acc_step = {sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (zero_div) begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
    end else if (is_div) begin
      fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else if (sign_a ^ sign_b) begin
      {fix_hi, fix_lo} = -acc;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      is_div          <= 1'b0;
      zero_div        <= 1'b0;
      sign_a          <= 1'b0;
      sign_b          <= 1'b0;
      cnt             <= '0;
      addend          <= '0;
      acc             <= '0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        is_div          <= bus.op[1];
        zero_div        <= req_zero_div;
        sign_a          <= signed_mode & bus.a[WIDTH-1];
        sign_b          <= signed_mode & bus.b[WIDTH-1];
        cnt             <= '0;
        bus.div_by_zero <= 1'b0;
        addend          <= bus.op[1] ? mag_b : mag_a;
        // divide-by-zero parks the raw dividend and all-ones quotient for FIX to publish
        if (req_zero_div) acc <= {bus.a, {WIDTH{1'b1}}};
        else              acc <= {{WIDTH{1'b0}}, bus.op[1] ? mag_a : mag_b};
      end else if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        bus.hi          <= fix_hi;
        bus.lo          <= fix_lo;
        bus.done        <= 1'b1;
        bus.div_by_zero <= zero_div;
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit at WIDTH=32 and WIDTH=8
module tb_hilo_muldiv_unit;
  logic   clock = 1'b0;
  logic   clear32, clear8;
  longint cycle = 0;
  int     checks = 0;
  int     failures = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus32 ();
  hilo_muldiv_unit_if #(.WIDTH(8))  bus8 ();

  hilo_muldiv_unit #(.WIDTH(32)) dut32 (.clock(clock), .clear(clear32), .bus(bus32));
  hilo_muldiv_unit #(.WIDTH(8))  dut8  (.clock(clock), .clear(clear8),  .bus(bus8));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    longint      acc_cycle;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  logic [31:0] last_hi[2];
  logic [31:0] last_lo[2];
  logic        last_dz[2];
  int          busy_cnt[2];

  task automatic check(string name, longint unsigned act, longint unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycle);
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended operands
  function automatic exp_t model(int w, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint unsigned mask, ua, ub, p, hiv, lov;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (((ua >> (w - 1)) & 64'd1) == 64'd1) sa = sa - longint'(64'd1 << w);
    if (((ub >> (w - 1)) & 64'd1) == 64'd1) sb = sb - longint'(64'd1 << w);
    e.dz = 1'b0;
    e.lat = w + 1;
    p = 0;
    hiv = 0;
    lov = 0;
    case (op)
      2'd0: begin p = longint'(sa * sb); hiv = (p >> w) & mask; lov = p & mask; end
      2'd1: begin p = ua * ub; hiv = (p >> w) & mask; lov = p & mask; end
      default: begin
        if (ub == 0) begin
          hiv = ua; lov = mask; e.dz = 1'b1; e.lat = 1;
        end else if (op == 2'd2) begin
          lov = longint'(sa / sb) & mask;
          hiv = longint'(sa % sb) & mask;
        end else begin
          lov = ua / ub;
          hiv = ua % ub;
        end
      end
    endcase
    e.hi = hiv[31:0];
    e.lo = lov[31:0];
    e.acc_cycle = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick(int w);
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return mask;
      3:       return 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic drive(bit w8, logic s, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (w8) begin
      bus8.start = s; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.start = s; bus32.op = op; bus32.a = a; bus32.b = b;
    end
  endtask

  task automatic issue(bit w8, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int   n = 0;
    e = model(w8 ? 8 : 32, op, a, b);
    @(negedge clock);
    while ((w8 ? bus8.busy : bus32.busy) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=idle within 100 cycles");
      return;
    end
    drive(w8, 1'b1, op, a, b);
    e.acc_cycle = cycle + 1;
    if (w8) q8.push_back(e);
    else    q32.push_back(e);
    @(negedge clock);
    drive(w8, 1'b0, 2'($urandom), $urandom, $urandom);
  endtask

  task automatic ignore_test(bit w8);
    issue(w8, 2'd1, 32'h0000_00A5, 32'h0000_003C);
    repeat (3) @(negedge clock);
    drive(w8, 1'b1, 2'd0, 32'hFFFF_FF81, 32'h0000_0077);
    @(negedge clock);
    drive(w8, 1'b0, 2'd0, 32'd0, 32'd0);
  endtask

  task automatic clear_test(bit w8);
    issue(w8, 2'd3, 32'h0000_0034, 32'd0);
    issue(w8, 2'd1, 32'h0000_0005, 32'h0000_0007);
    repeat (3) @(posedge clock);
    #2;
    if (w8) clear8 = 1'b0;
    else    clear32 = 1'b0;
    #1;
    if (w8) begin
      check("clr8_busy", bus8.busy, 0); check("clr8_done", bus8.done, 0);
      check("clr8_dz", bus8.div_by_zero, 0);
      check("clr8_hi", bus8.hi, 0); check("clr8_lo", bus8.lo, 0);
      q8.delete();
    end else begin
      check("clr32_busy", bus32.busy, 0); check("clr32_done", bus32.done, 0);
      check("clr32_dz", bus32.div_by_zero, 0);
      check("clr32_hi", bus32.hi, 0); check("clr32_lo", bus32.lo, 0);
      q32.delete();
    end
    @(posedge clock);
    #2;
    if (w8) clear8 = 1'b1;
    else    clear32 = 1'b1;
  endtask

  task automatic mon(bit w8);
    logic        clr, dn, bsy, dz;
    logic [31:0] hi, lo;
    exp_t        e;
    int          k;
    k = w8 ? 1 : 0;
    if (w8) begin
      clr = clear8; dn = bus8.done; bsy = bus8.busy; dz = bus8.div_by_zero;
      hi = 32'(bus8.hi); lo = 32'(bus8.lo);
    end else begin
      clr = clear32; dn = bus32.done; bsy = bus32.busy; dz = bus32.div_by_zero;
      hi = bus32.hi; lo = bus32.lo;
    end
    if (!clr) begin
      last_hi[k] = 0; last_lo[k] = 0; last_dz[k] = 0; busy_cnt[k] = 0;
      return;
    end
    if (dn) begin
      if ((w8 ? q8.size() : q32.size()) == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_pending w8=%0d", w8);
      end else begin
        if (w8) e = q8.pop_front();
        else    e = q32.pop_front();
        check(w8 ? "hi8" : "hi32", hi, e.hi);
        check(w8 ? "lo8" : "lo32", lo, e.lo);
        check(w8 ? "dz8" : "dz32", dz, e.dz);
        check(w8 ? "latency8" : "latency32", cycle - e.acc_cycle, e.lat);
        check(w8 ? "busy_cycles8" : "busy_cycles32", busy_cnt[k], e.lat);
      end
      last_hi[k] = hi; last_lo[k] = lo; last_dz[k] = dz; busy_cnt[k] = 0;
    end else begin
      if (bsy) busy_cnt[k]++;
      check(w8 ? "hold_hi8" : "hold_hi32", hi, last_hi[k]);
      check(w8 ? "hold_lo8" : "hold_lo32", lo, last_lo[k]);
      check(w8 ? "dz_state8" : "dz_state32", dz, bsy ? 1'b0 : last_dz[k]);
    end
  endtask

  always @(negedge clock) begin
    mon(1'b0);
    mon(1'b1);
  end

  initial begin
    int n;
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    clear32 = 1'b0;
    clear8 = 1'b0;
    #8;
    check("rst32_busy", bus32.busy, 0); check("rst32_done", bus32.done, 0);
    check("rst32_dz", bus32.div_by_zero, 0);
    check("rst32_hi", bus32.hi, 0); check("rst32_lo", bus32.lo, 0);
    check("rst8_busy", bus8.busy, 0); check("rst8_done", bus8.done, 0);
    check("rst8_dz", bus8.div_by_zero, 0);
    check("rst8_hi", bus8.hi, 0); check("rst8_lo", bus8.lo, 0);
    #9;
    clear32 = 1'b1;
    clear8 = 1'b1;

    issue(1'b0, 2'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    issue(1'b0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 32'hFFFF_FFEF, 32'h0000_0005);
    issue(1'b0, 2'd2, 32'h0000_0011, 32'hFFFF_FFFB);
    issue(1'b0, 2'd3, 32'h0000_1234, 32'h0000_0000);
    issue(1'b0, 2'd1, 32'h0000_0002, 32'h0000_0003);
    issue(1'b0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    ignore_test(1'b0);
    clear_test(1'b0);
    for (int i = 0; i < 30; i++) begin
      issue(1'b0, 2'($urandom_range(0, 3)), pick(32), pick(32));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    issue(1'b1, 2'd0, 32'h0000_0080, 32'h0000_0080);
    issue(1'b1, 2'd2, 32'h0000_0080, 32'h0000_00FF);
    issue(1'b1, 2'd3, 32'h0000_0012, 32'h0000_0000);
    ignore_test(1'b1);
    clear_test(1'b1);
    for (int i = 0; i < 60; i++) begin
      issue(1'b1, 2'($urandom_range(0, 3)), pick(8), pick(8));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", q32.size(), q8.size());
    end
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multi-cycle multiply/divide unit that produces the 2×WIDTH result pair destined for the HI and LO registers of the CPU datapath. It takes two WIDTH-bit operands and a mode from the control unit on a start pulse, iterates one bit per clock, and reports completion with a one-cycle done pulse. Signed and unsigned multiply and divide are supported, with explicit divide-by-zero handling. This replaces the single-cycle combinational MUL/DIV path inside the ALU.

## Interface
- WIDTH, 32, operand width in bits; legal values are 4 and above; hi and lo are each WIDTH bits.
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  mode: 00 MUL signed, 01 MULU unsigned, 10 DIV signed, 11 DIVU unsigned; captured with start.
- a  in  WIDTH  multiplicand/dividend; captured with start.
- b  in  WIDTH  multiplier/divisor; captured with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when hi/lo are updated.
- div_by_zero  out  1  set with done when a DIV/DIVU had b=0; held until the next accepted start.
- hi  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- lo  out  WIDTH  MUL: product[W-1:0]; DIV: quotient.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1:
  - Capture op.
  - Capture |a| and |b| as W-bit unsigned magnitudes; signed modes only. The magnitude of the most-negative value is 2^(W-1).
  - Capture sign_a and sign_b; both are 0 in unsigned modes.
  - Clear the iteration counter and clear div_by_zero.
  - Go to RUN. If op is DIV/DIVU and b==0, go to FIX instead.
- RUN runs exactly WIDTH iterations, counter 0..WIDTH-1, then goes to FIX.
  - Multiply: unsigned shift-add on magnitudes into a 2W-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division on magnitudes, one quotient bit per cycle, MSB first. Keep a W+1-bit partial remainder for the trial subtract.
- FIX: apply signs, write hi/lo, pulse done, return to IDLE.
  - MUL: negate the 2W-bit product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a. The remainder takes the dividend's sign and the quotient truncates toward zero.
  - Divide by zero: hi=a (original value), lo=all ones, div_by_zero=1.
- Overflow case, signed DIV of most-negative by −1: the quotient wraps to the most-negative value (lo=100…0) and hi=0. No flag is raised.
- hi/lo hold their value from done until the next FIX. They do not change during RUN.
- start is ignored while busy=1; there is no queueing.

## Timing
- Reset (clear=0, asynchronous): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. An in-flight operation is abandoned.
- Accepting edge E0 is the IDLE edge with start=1. busy rises after E0.
- Normal operation: RUN covers edges E1..EW. The FIX edge is E(W+1), after which done=1, busy=0 and hi/lo are valid.
  - Latency: W+1 clocks from acceptance, i.e. 33 clocks for WIDTH=32.
- Divide by zero: the FIX edge is E1, giving a latency of 1 clock.
- done is high for exactly one cycle. The cycle in which done=1 is an IDLE cycle, so a start in that cycle is accepted (back-to-back throughput of W+2 clocks).
- div_by_zero changes only at FIX and at acceptance.
- Inputs a, b and op may change freely after the accepting edge.

## Test plan
- Signed multiply, WIDTH=32: MUL a=0xFFFFFFFD, b=7 -> done 33 clocks after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for exactly 33 cycles.
- Unsigned multiply: MULU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - Repeat as MUL, which is (−1)·(−1) -> hi=0, lo=1.
- Signed divide: DIV a=0xFFFFFFEF (−17), b=5 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFE (−2).
  - Repeat as DIV 17/−5 -> lo=0xFFFFFFFD, hi=0x00000002.
- Divide by zero: DIVU a=0x00001234, b=0 -> done 1 clock after acceptance, hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1.
  - A following MULU 2×3 clears the flag at acceptance and gives hi=0, lo=6.
- Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Control behaviour, both WIDTH=32 and WIDTH=8:
  - A start pulse mid-RUN with different operands is ignored and the result matches the first request.
  - clear dropped mid-RUN zeroes all outputs immediately (before the next clock edge).
  - A start accepted in the same cycle as done completes normally.
  - For WIDTH=8: MUL 0x80×0x80 -> hi=0x40, lo=0x00.
